// File: rtl/speechrec_pkg.sv
// Types and constants shared by the audio feature extractor and the template matcher.
package speechrec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VOICE,
        CAPTURE,
        DONE
    } feat_state_t;

    localparam logic [7:0] MIDSCALE       = 8'd128;
    localparam int         FRAME_LEN_DEF  = 64;
    localparam int         NUM_FRAMES_DEF = 16;

endpackage

// File: rtl/frame_accum.sv
// Per-frame mean absolute deviation from midscale.
// Emits a registered energy pulse one cycle after a frame's last sample is accepted.
module frame_accum
    import speechrec_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    input  logic       i_clr,
    input  logic [7:0] i_sample,
    output logic       o_last,
    output logic [7:0] o_energy_next,
    output logic       frame_valid,
    output logic [7:0] frame_energy
);

    localparam int LOG2 = $clog2(FRAME_LEN);
    localparam int AW   = 8 + LOG2;

    logic [7:0]      w_dev;
    logic [AW-1:0]   w_sum;
    logic [AW-1:0]   r_acc;
    logic [LOG2-1:0] r_cnt;

    assign w_dev         = i_sample[7] ? (i_sample - MIDSCALE) : (MIDSCALE - i_sample);
    assign w_sum         = r_acc + AW'(w_dev);
    assign o_last        = i_en && (r_cnt == LOG2'(FRAME_LEN - 1));
    // Sum is at most FRAME_LEN*128, so the top 8 bits hold the whole quotient.
    assign o_energy_next = w_sum[LOG2 +: 8];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            frame_valid  <= 1'b0;
            frame_energy <= 8'd0;
        end else begin
            frame_valid <= o_last;
            if (o_last)
                frame_energy <= o_energy_next;
            if (i_clr) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (i_en) begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= o_last ? '0 : w_sum;
            end
        end
    end

endmodule

// File: rtl/audio_features.sv
// Voice-triggered capture of NUM_FRAMES consecutive frame energies into a small
// register-array feature memory read combinationally by the template matcher.
module audio_features
    import speechrec_pkg::*;
#(
    parameter int FRAME_LEN  = FRAME_LEN_DEF,
    parameter int NUM_FRAMES = NUM_FRAMES_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          sample_valid,
    input  logic [7:0]                    sample,
    output logic                          sample_ready,
    input  logic [7:0]                    thresh,
    output logic                          frame_valid,
    output logic [7:0]                    frame_energy,
    output logic                          done,
    input  logic [$clog2(NUM_FRAMES)-1:0] rd_addr,
    output logic [7:0]                    rd_data
);

    localparam int AW = $clog2(NUM_FRAMES);

    feat_state_t   r_state;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_mem [NUM_FRAMES];

    logic          w_accept;
    logic          w_arm;
    logic          w_last;
    logic [7:0]    w_energy;
    logic          w_voice;
    logic          w_wr;
    logic [AW-1:0] w_wr_addr;

    assign sample_ready = (r_state == WAIT_VOICE) || (r_state == CAPTURE);
    assign w_accept     = sample_valid && sample_ready;
    assign w_arm        = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_voice      = w_energy >= thresh;
    assign w_wr         = w_last && (((r_state == WAIT_VOICE) && w_voice) || (r_state == CAPTURE));
    assign w_wr_addr    = (r_state == WAIT_VOICE) ? '0 : r_addr;
    assign done         = (r_state == DONE);
    assign rd_data      = r_mem[rd_addr];

    frame_accum #(
        .FRAME_LEN(FRAME_LEN)
    ) u_accum (
        .clk          (clk),
        .reset        (reset),
        .i_en         (w_accept),
        .i_clr        (w_arm),
        .i_sample     (sample),
        .o_last       (w_last),
        .o_energy_next(w_energy),
        .frame_valid  (frame_valid),
        .frame_energy (frame_energy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= WAIT_VOICE;
                        r_addr  <= '0;
                    end
                end
                WAIT_VOICE: begin
                    if (w_last && w_voice) begin
                        r_state <= CAPTURE;
                        r_addr  <= AW'(1);
                    end
                end
                CAPTURE: begin
                    if (w_last) begin
                        r_addr <= r_addr + 1'b1;
                        if (r_addr == AW'(NUM_FRAMES - 1))
                            r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // No reset on the array: contents persist and are only meaningful while done is high.
    always_ff @(posedge clk) begin
        if (!reset && w_wr)
            r_mem[w_wr_addr] <= w_energy;
    end

endmodule

// File: tb/tb_audio_features.sv
// Randomized bench for audio_features with a frame-level reference model.
module tb_audio_features;

    localparam int FL = 64;
    localparam int NF = 16;
    localparam int AW = $clog2(NF);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          sample_valid;
    logic [7:0]    sample;
    logic [7:0]    thresh;
    logic [AW-1:0] rd_addr;
    logic          sample_ready;
    logic          frame_valid;
    logic [7:0]    frame_energy;
    logic          done;
    logic [7:0]    rd_data;

    int checks = 0;
    int errors = 0;

    int exp_q[$];
    int got_q[$];
    int m_idx;
    int m_vec [NF];

    always #5 clk = ~clk;

    audio_features #(.FRAME_LEN(FL), .NUM_FRAMES(NF)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .sample_valid(sample_valid),
        .sample      (sample),
        .sample_ready(sample_ready),
        .thresh      (thresh),
        .frame_valid (frame_valid),
        .frame_energy(frame_energy),
        .done        (done),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    always @(negedge clk) if (frame_valid) got_q.push_back(int'(frame_energy));

    // Model of the feature vector: first frame at/above threshold, then the following frames.
    task automatic model_store(input int e);
        if (m_idx < 0) begin
            if (e >= int'(thresh)) begin
                m_vec[0] = e;
                m_idx = 1;
            end
        end else if (m_idx < NF) begin
            m_vec[m_idx] = e;
            m_idx++;
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        got_q.delete();
        m_idx = -1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; sample_valid = 1'b0; sample = 8'd0;
        cycles(2);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        model_clear();
    endtask

    task automatic send(input logic [7:0] s);
        sample_valid = 1'b1;
        sample = s;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // mode 0: constant c, 1: alternating 0/255, 2: uniform random, 3: loud random
    task automatic send_frames(input int n, input int mode, input int c);
        for (int f = 0; f < n; f++) begin
            int sum = 0;
            for (int i = 0; i < FL; i++) begin
                int s;
                case (mode)
                    0:       s = c;
                    1:       s = (i % 2 == 0) ? 0 : 255;
                    2:       s = int'($urandom_range(0, 255));
                    default: s = int'($urandom_range(200, 255));
                endcase
                sum += (s >= 128) ? s - 128 : 128 - s;
                send(8'(s));
            end
            exp_q.push_back(sum / FL);
            model_store(sum / FL);
        end
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; sample_valid = 1'b0; sample = 8'd0;
        thresh = 8'd1; rd_addr = '0;
        cycles(3);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid got %b want 0", frame_valid); end
        checks++; if (frame_energy !== 8'd0) begin errors++; $display("FAIL reset_frame_energy got %0d want 0", frame_energy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", sample_ready); end
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_silence();
        thresh = 8'd1;
        pulse_start();
        send_frames(1, 0, 128);
        cycles(2);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL silence_count got %0d want 1", got_q.size()); end
        else begin
            checks++; if (got_q[0] != 0) begin errors++; $display("FAIL silence_energy got %0d want 0", got_q[0]); end
        end
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL silence_still_waiting got %b want 1", sample_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL silence_done got %b want 0", done); end
    endtask

    task automatic test_threshold();
        do_reset();
        thresh = 8'd20;
        pulse_start();
        send_frames(2, 0, 147);
        send_frames(1, 0, 148);
        send_frames(1, 1, 0);
        send_frames(13, 2, 0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL thr_done_early got %b want 0", done); end
        send_frames(1, 2, 0);
        checks++; if (frame_valid !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL thr_done_with_last got fv=%b done=%b want 1 1", frame_valid, done); end
        cycles(2);
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL thr_ready_after_done got %b want 0", sample_ready); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL thr_frame_count got %0d want %0d", got_q.size(), exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL thr_energy[%0d] got %0d want %0d", i, got_q[i], exp_q[i]); end
            end
        end
        checks++; if (exp_q[0] != 19 || exp_q[2] != 20 || exp_q[3] != 127) begin errors++; $display("FAIL thr_model_boundaries got %0d %0d %0d want 19 20 127", exp_q[0], exp_q[2], exp_q[3]); end
        for (int a = 0; a < NF; a++) begin
            rd_addr = AW'(a); #1;
            checks++; if (int'(rd_data) != m_vec[a]) begin errors++; $display("FAIL thr_mem[%0d] got %0d want %0d", a, rd_data, m_vec[a]); end
        end
        rd_addr = '0; #1;
        checks++; if (rd_data !== 8'd20) begin errors++; $display("FAIL thr_mem0 got %0d want 20", rd_data); end
        rd_addr = AW'(1); #1;
        checks++; if (rd_data !== 8'd127) begin errors++; $display("FAIL thr_mem1 got %0d want 127", rd_data); end
    endtask

    task automatic test_done_zeros();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL dz_precond_done got %b want 1", done); end
        pulse_start();
        checks++; if (done !== 1'b0 || sample_ready !== 1'b1) begin errors++; $display("FAIL dz_rearm got done=%b ready=%b want 0 1", done, sample_ready); end
        send_frames(1, 0, 200);
        send_frames(15, 0, 0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL dz_done got %b want 1", done); end
        rd_addr = '0; #1;
        checks++; if (rd_data !== 8'd72) begin errors++; $display("FAIL dz_mem0 got %0d want 72", rd_data); end
        for (int a = 1; a < NF; a++) begin
            rd_addr = AW'(a); #1;
            checks++; if (rd_data !== 8'd128) begin errors++; $display("FAIL dz_mem[%0d] got %0d want 128", a, rd_data); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        thresh = 8'($urandom_range(10, 60));
        pulse_start();
        send_frames(1, 3, 0);
        for (int i = 0; i < 30; i++) send(8'($urandom_range(0, 255)));
        sample_valid = 1'b0;
        do_reset();
        checks++; if (done !== 1'b0 || frame_valid !== 1'b0) begin errors++; $display("FAIL mid_reset got done=%b fv=%b want 0 0", done, frame_valid); end
        pulse_start();
        send_frames(1, 3, 0);
        send_frames(14, 2, 0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done_early got %b want 0", done); end
        send_frames(1, 2, 0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL mid_done got %b want 1", done); end
        cycles(2);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL mid_frame_count got %0d want %0d", got_q.size(), exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL mid_energy[%0d] got %0d want %0d", i, got_q[i], exp_q[i]); end
            end
        end
        for (int a = 0; a < NF; a++) begin
            rd_addr = AW'(a); #1;
            checks++; if (int'(rd_data) != m_vec[a]) begin errors++; $display("FAIL mid_mem[%0d] got %0d want %0d", a, rd_data, m_vec[a]); end
        end
    endtask

    task automatic test_start_ignored();
        thresh = 8'd30;
        pulse_start();
        start = 1'b1;
        send_frames(1, 3, 0);
        send_frames(5, 2, 0);
        start = 1'b1;
        send_frames(1, 2, 0);
        checks++; if (sample_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ign_state got ready=%b done=%b want 1 0", sample_ready, done); end
        send_frames(9, 2, 0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_done got %b want 1", done); end
        cycles(2);
        checks++; if (got_q.size() != NF) begin errors++; $display("FAIL ign_frame_count got %0d want %0d", got_q.size(), NF); end
        for (int a = 0; a < NF; a++) begin
            rd_addr = AW'(a); #1;
            checks++; if (int'(rd_data) != m_vec[a]) begin errors++; $display("FAIL ign_mem[%0d] got %0d want %0d", a, rd_data, m_vec[a]); end
        end
    endtask

    initial begin
        test_reset();
        test_silence();
        test_threshold();
        test_done_zeros();
        test_reset_mid();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
